// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit-to-16-bit SRAM controller:
// FSM encoding, default address map and SRAM geometry.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          SRAM_AW           = 18;
  localparam int          SRAM_WORD_W       = SRAM_AW - 1;

  // 32-bit word index inside the SRAM for a CPU byte address. The offset
  // wraps modulo 2^32; byte-lane bits and bits above the SRAM size drop out.
  function automatic logic [SRAM_WORD_W-1:0] sram_word(input logic [31:0] addr,
                                                       input logic [31:0] base);
    return SRAM_WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side memory port of the SRAM controller.
//
// Handshake: wr_en / rd_en act as a level "valid". The requester holds the
// request, address and write data stable until it sees ready=1; the access
// is retired in exactly that cycle, and read_data is valid in that cycle
// for a read. ready=0 stalls the pipeline. A request still asserted in the
// cycle after ready=1 is taken as a new access.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// SRAM controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses (low half, then high half), each lasting PHASE_CYCLES clocks.
// All SRAM pins are registered; ready is combinational so the pipeline can
// freeze in the same cycle a request appears.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output logic [1:0]         state_o
);

  localparam logic [3:0] PHASE_LAST = 4'(PHASE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_wr_q;
  logic [SRAM_WORD_W-1:0] word_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [SRAM_AW-1:0]     sram_addr_q;
  logic [15:0]            dq_out_q;
  logic                   dq_oe_q;
  logic                   we_n_q, oe_n_q, ce_n_q, ub_n_q, lb_n_q;

  logic                   start;
  logic                   phase_last;
  logic                   op_wr_d;
  logic [SRAM_WORD_W-1:0] word_d;
  logic [31:0]            wdata_d;
  logic                   active_d;

  assign start      = bus.rd_en | bus.wr_en;
  assign phase_last = (cnt_q == PHASE_LAST);

  // In IDLE the operation about to start comes straight from the port (it is
  // latched on the same edge); afterwards the latched copy drives the pins.
  assign op_wr_d  = (state_q == ST_IDLE) ? bus.wr_en : op_wr_q;
  assign word_d   = (state_q == ST_IDLE) ? sram_word(bus.address, BASE_ADDR) : word_q;
  assign wdata_d  = (state_q == ST_IDLE) ? bus.write_data : wdata_q;
  assign active_d = (state_d == ST_LOW) || (state_d == ST_HIGH);

  // Next state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, request latches, read capture and registered SRAM strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (state_q == ST_IDLE && start) begin
        op_wr_q <= bus.wr_en;
        word_q  <= sram_word(bus.address, BASE_ADDR);
        wdata_q <= bus.write_data;
      end

      // Read data is sampled at the end of each phase, after the SRAM has
      // had the full phase to settle.
      if (state_q == ST_LOW && phase_last && !op_wr_q) begin
        rdata_q[15:0] <= sram_dq_in;
      end
      if (state_q == ST_HIGH && phase_last && !op_wr_q) begin
        rdata_q[31:16] <= sram_dq_in;
      end

      ce_n_q  <= ~active_d;
      ub_n_q  <= ~active_d;
      lb_n_q  <= ~active_d;
      oe_n_q  <= ~(active_d & ~op_wr_d);
      dq_oe_q <= active_d & op_wr_d;
      // Write strobe released on the last phase cycle so data and address
      // are held for one cycle after the rising edge of WE#.
      we_n_q  <= ~(active_d & op_wr_d & (cnt_d != PHASE_LAST));

      if (active_d) begin
        sram_addr_q <= {word_d, (state_d == ST_HIGH)};
      end
      if (active_d && op_wr_d) begin
        dq_out_q <= (state_d == ST_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
      end
    end
  end

  assign bus.ready     = (~bus.rd_en & ~bus.wr_en & (state_q == ST_IDLE)) |
                         (state_q == ST_DONE);
  assign bus.read_data = rdata_q;
  assign sram_addr     = sram_addr_q;
  assign sram_dq_out   = dq_out_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_we_n     = we_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_ub_n     = ub_n_q;
  assign sram_lb_n     = lb_n_q;
  assign state_o       = state_q;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: BASE_ADDR, default 1024, byte address that maps to SRAM word 0.
REQ-002 Parameter: PHASE_CYCLES, default 2, clock cycles spent on each 16-bit half access (legal range 2..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; the port SHALL be asynchronous and active-low (0 = reset).
REQ-005 wr_en  in  1  memory-stage write request, level, held until ready=1.
REQ-006 rd_en  in  1  memory-stage read request, level, held until ready=1.
REQ-007 address  in  32  byte address from the ALU result.
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  load data, valid in the cycle ready=1 after a read.
REQ-010 ready  out  1  0 = stall the pipeline (feeds the freeze path).
REQ-011 sram_addr  out  18  SRAM halfword address.
REQ-012 sram_dq_out  out  16  write data to SRAM.
REQ-013 sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus.
REQ-014 sram_dq_in  in  16  read data from SRAM.
REQ-015 sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Function
REQ-016 Address map: offset = address - BASE_ADDR (32-bit, wrap); word = offset[18:2]; low half at sram_addr={word,0}, high half at {word,1}; offset bits [1:0] and [31:19] ignored.
REQ-017 FSM states: IDLE, LOW, HIGH, DONE; a phase counter counts 0..PHASE_CYCLES-1 in LOW and HIGH.
REQ-018 IDLE: on rd_en|wr_en, latch op (write if wr_en, else read), address and write_data; go to LOW with counter 0.
REQ-019 LOW/HIGH: hold the state while counter < PHASE_CYCLES-1; at counter = PHASE_CYCLES-1, LOW goes to HIGH (counter 0) and HIGH goes to DONE.
REQ-020 DONE: ready=1 for exactly one cycle, then go to IDLE.
REQ-021 ready = (~rd_en & ~wr_en & state==IDLE) | state==DONE, combinational.
REQ-022 Total latency: the request cycle plus 2*PHASE_CYCLES cycles at ready=0, then one DONE cycle at ready=1 (default: 5 stall cycles).
REQ-023 Read: sram_oe_n=0 throughout LOW/HIGH; read_data[15:0] is captured from sram_dq_in on the last LOW cycle and read_data[31:16] on the last HIGH cycle; read_data holds until the next read completes.
REQ-024 Write: sram_dq_oe=1 throughout LOW/HIGH with the latched half (low in LOW, high in HIGH); sram_we_n=0 on all phase cycles except the last one, giving 1 cycle of hold.
REQ-025 sram_ce_n=0, sram_ub_n=0 and sram_lb_n=0 in LOW/HIGH, and 1 otherwise; sram_addr holds its value except in LOW/HIGH.
REQ-026 rd_en and wr_en both 1: the write wins.
REQ-027 A request dropped mid-access does not abort the access; it completes to DONE.
REQ-028 A request still asserted in IDLE right after DONE is treated as a new request.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, counter 0, read_data 0, latches 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, and all strobes 1.
REQ-030 Reset asserted mid-access abandons the access; no partial write is retried.

Structure
REQ-031 A shared package holds the FSM state encoding (2-bit), the BASE_ADDR default and the SRAM address width (18).
REQ-032 A single module; the phase counter stays inline, with no sub-module.

Verification
REQ-033 Write 0xDEADBEEF to 1024 -> halfword 0 = 0xBEEF, halfword 1 = 0xDEAD; ready=0 for 5 cycles, then 1 for one cycle.
REQ-034 Read 1024 after REQ-033 (SRAM model) -> read_data = 0xDEADBEEF in the ready=1 cycle; sram_we_n stays 1 throughout.
REQ-035 Write 0x12345678 to 1028 and 0xCAFEF00D to 1032 back-to-back -> SRAM halfword addrs 2/3 and 4/5 are correct; one IDLE cycle with ready=0 between the two accesses.
REQ-036 rd_en=wr_en=1, address 1040, data 0x0000FFFF -> a write occurs at halfwords 8/9; read_data unchanged.
REQ-037 rst pulsed low in the HIGH state of a write -> outputs immediately take their reset values; FSM restarts in IDLE; the next read at 1024 completes normally.
REQ-038 PHASE_CYCLES=4, read -> ready=0 for 9 cycles; sram_we_n never 0; capture happens on the 4th cycle of each phase.
